// File: rtl/lvds_pkg.sv
// Shared definitions for the single-lane LVDS link (receiver and transmitter).
// FSM state encodings, default sync pattern, error-counter width and a saturating increment.
package lvds_pkg;

  typedef logic [1:0] lvds_state_t;

  localparam lvds_state_t ST_HUNT    = 2'd0;
  localparam lvds_state_t ST_PAYLOAD = 2'd1;
  localparam lvds_state_t ST_SYNC    = 2'd2;
  localparam lvds_state_t ST_PARITY  = 2'd3;

  localparam logic [15:0] LVDS_SYNC_WORD_DEFAULT = 16'hABCD;
  localparam int          LVDS_ERR_W             = 16;

  function automatic logic [LVDS_ERR_W-1:0] sat_inc(input logic [LVDS_ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lvds_bit_sync.sv
// Two-flop synchroniser for a single bit, asynchronously cleared by rst_n.
module lvds_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: every flop here is a register, so all updates use <= to avoid ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lvds_frame_rx.sv
// Bit-serial LVDS frame receiver: sync-word hunt, MSB-first payload deframing, lock and error tracking.
// Optional even-parity bit after each payload when LVDS_FRAME_RX_PARITY_EN is defined.
module lvds_frame_rx
  import lvds_pkg::*;
#(
  parameter int                    SYNC_WIDTH    = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = SYNC_WIDTH'(LVDS_SYNC_WORD_DEFAULT),
  parameter int                    PAYLOAD_WIDTH = 8,
  parameter int                    MAX_MISS      = 3
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic [0:0]               LVDS_RX_P,
  output logic [PAYLOAD_WIDTH-1:0] Data,
  output logic                     Valid,
  output logic                     Locked,
  output logic                     SyncError,
  output logic [LVDS_ERR_W-1:0]    ErrorCount
);

  localparam int MAX_LEN = (SYNC_WIDTH > PAYLOAD_WIDTH) ? SYNC_WIDTH : PAYLOAD_WIDTH;
  localparam int CNT_W   = $clog2(MAX_LEN);
  localparam int MISS_W  = $clog2(MAX_MISS + 1);
`ifdef LVDS_FRAME_RX_PARITY_EN
  localparam int SHR_W   = PAYLOAD_WIDTH;
`else
  // The final payload bit is taken straight from the line, so one bit less is stored.
  localparam int SHR_W   = PAYLOAD_WIDTH - 1;
`endif

  logic                  rst_n_sync;
  logic                  rx_bit;
  lvds_state_t           state;
  logic [SYNC_WIDTH-1:0] window;
  logic [SYNC_WIDTH-1:0] window_nxt;
  logic [SHR_W-1:0]      shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [MISS_W-1:0]     miss_cnt;

  // Reset asserts asynchronously but releases two clocks later, aligned to Clk.
  lvds_bit_sync u_rst_sync (.clk(Clk), .rst_n(nReset), .d(1'b1),         .q(rst_n_sync));
  lvds_bit_sync u_rx_sync  (.clk(Clk), .rst_n(nReset), .d(LVDS_RX_P[0]), .q(rx_bit));

  assign window_nxt = {window[SYNC_WIDTH-2:0], rx_bit};

  always_ff @(posedge Clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state      <= ST_HUNT;
      window     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      miss_cnt   <= '0;
      Data       <= '0;
      Valid      <= 1'b0;
      Locked     <= 1'b0;
      SyncError  <= 1'b0;
      ErrorCount <= '0;
    end else begin
      Valid     <= 1'b0;
      SyncError <= 1'b0;
      case (state)
        ST_HUNT: begin
          window <= window_nxt;
          if (window_nxt == SYNC_WORD) begin
            state   <= ST_PAYLOAD;
            bit_cnt <= '0;
          end
        end

        ST_PAYLOAD: begin
          shreg   <= SHR_W'({shreg, rx_bit});
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(PAYLOAD_WIDTH - 1)) begin
            bit_cnt <= '0;
`ifdef LVDS_FRAME_RX_PARITY_EN
            state   <= ST_PARITY;
`else
            Data    <= {shreg, rx_bit};
            Valid   <= 1'b1;
            state   <= ST_SYNC;
`endif
          end
        end

`ifdef LVDS_FRAME_RX_PARITY_EN
        ST_PARITY: begin
          state <= ST_SYNC;
          if (^{shreg, rx_bit} == 1'b0) begin
            Data  <= shreg;
            Valid <= 1'b1;
          end else begin
            ErrorCount <= sat_inc(ErrorCount);
          end
        end
`else
        ST_PARITY: state <= ST_HUNT;
`endif

        ST_SYNC: begin
          window  <= window_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(SYNC_WIDTH - 1)) begin
            bit_cnt <= '0;
            if (window_nxt == SYNC_WORD) begin
              Locked   <= 1'b1;
              miss_cnt <= '0;
              state    <= ST_PAYLOAD;
            end else begin
              SyncError  <= 1'b1;
              ErrorCount <= sat_inc(ErrorCount);
              if (miss_cnt == MISS_W'(MAX_MISS - 1)) begin
                // Drop lock and restart the hunt from an empty window.
                Locked   <= 1'b0;
                miss_cnt <= '0;
                window   <= '0;
                state    <= ST_HUNT;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
                state    <= ST_PAYLOAD;
              end
            end
          end
        end

        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule
